i2s_frame_capture: RTL and testbench
====================================

# i2s_frame_capture

Downstream consumer of the S/PDIF decoder's I2S outputs (`i2s_bck`, `i2s_ws`, `i2s_d0`), all generated in the same `clk` domain. It oversamples the I2S lines with `clk` and deserializes MSB-first words into left/right sample pairs. Pairs are buffered in a small show-ahead FIFO and delivered over a valid/ready handshake to the audio back end. It also flags a lost bit clock, short words and dropped pairs.

## Interface
- `WIDTH`, default 24: sample width in bits, 8..24.
- `DEPTH`, default 4: FIFO depth in L/R pairs, power of two, 2..16.
- `TIMEOUT`, default 255: `clk` cycles without a `bck` rising edge before declaring loss of lock. Range 2..255, held in an 8-bit counter.
- `clk`, in, 1: system clock, the same clock that drives the decoder.
- `resetb`, in, 1: reset, synchronous, active-low. Clock is `clk`.
- `i2s_bck`, in, 1: I2S bit clock, sampled by `clk`.
- `i2s_ws`, in, 1: word select. 0 = left, 1 = right.
- `i2s_d0`, in, 1: serial data, MSB first, standard I2S one-bit delay after a `ws` change.
- `sample_left`, out, WIDTH: left sample at the FIFO head.
- `sample_right`, out, WIDTH: right sample at the FIFO head.
- `sample_valid`, out, 1: FIFO not empty.
- `sample_ready`, in, 1: consumer accepts the head pair when `sample_valid` and `sample_ready` are both 1 in the same cycle.
- `locked`, out, 1: word alignment established and `bck` active.
- `short_word`, out, 1: sticky. A word closed with fewer than WIDTH bits.
- `overflow`, out, 1: sticky. A completed pair was dropped because the FIFO was full.
- `clear_flags`, in, 1: clears `short_word` and `overflow` on the next cycle. Any set event in the same cycle takes priority over the clear.

## Operation
- **Input stage.** `bck`, `ws` and `d0` are each registered once (`_q`). `bck_q` is registered again (`_qq`).
  - `rise` is `bck_q & !bck_qq`.
  - On `rise`, the block samples `ws_q` and `d0_q`.
- **FSM states.**
  - SYNC: reset state. On `rise`, latch `ws_prev = ws_q`. Stay in SYNC until a `rise` where `ws_q != ws_prev`. Then go to CAPTURE with `chan = ws_q`, `bitcnt = 0`, shift register cleared. `locked` = 0 in SYNC.
  - CAPTURE: on every `rise` where `ws_q == ws_prev`:
    - if `bitcnt < WIDTH`, shift `d0_q` in at the LSB and increment `bitcnt`;
    - extra bits beyond WIDTH are ignored.
  - CAPTURE, `ws` change: on a `rise` where `ws_q != ws_prev`, that edge's `d0_q` is the LSB of the old word. Shift it in if `bitcnt < WIDTH`, then close the word.
- **Closing a word.**
  - Final value is the shift register left-aligned. If fewer than WIDTH bits arrived, the missing LSBs are 0 and `short_word` is set.
  - Closed left word: stored in `left_hold`, and `left_valid` is set.
  - Closed right word with `left_valid` = 1: `{left_hold, right}` is pushed, and `left_valid` is cleared.
  - Closed right word with `left_valid` = 0: the word is discarded. This covers the first word after sync.
  - After closing, `chan` flips, `bitcnt` = 0 and the shift register is cleared.
- **Watchdog.** A counter counts `clk` cycles since the last `rise`. When it reaches TIMEOUT:
  - go to SYNC;
  - discard the partial word and `left_valid`;
  - `locked` = 0.
  - The FIFO contents are kept. The counter saturates and is reset by `rise`.
- **`locked`.** Set on the first pair push after entering CAPTURE. Cleared on entry to SYNC.
- **FIFO.** DEPTH entries of 2·WIDTH bits, show-ahead. Head data is valid combinationally whenever `sample_valid` = 1.
  - Push when full with no pop in the same cycle: the new pair is dropped and `overflow` is set.
  - Push and pop in the same cycle are always legal, including when full: occupancy is unchanged and no overflow.
  - Pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
- **Held state.** Outputs and FIFO are stable when there is no `rise`. A pop only happens through the handshake.

## Timing
- Reset values (cycle after `resetb` = 0 sampled): FSM = SYNC, FIFO empty, all outputs 0 (`sample_left`/`sample_right` = 0, `sample_valid`, `locked`, `short_word`, `overflow` = 0). Reset mid-word or with a full FIFO discards everything.
- Latency from the first `clk` where `i2s_bck` = 1 is seen, for the `bck` rising edge that closes a right word:
  - `rise` is detected 1 cycle later;
  - the push is registered 2 cycles later;
  - `sample_valid` = 1 at 2 cycles with the FIFO previously empty.
- Pop: `sample_valid & sample_ready` at cycle n → next pair at the head (or `sample_valid` = 0) at n+1.
- Minimum supported `bck` half-period: 2 `clk` cycles. The decoder's nominal ~17-cycle half-period is far inside this limit.

## Test plan
- **Reset.** Assert `resetb` = 0 for 2 cycles with random inputs → all outputs 0, `sample_valid` = 0.
- **Basic capture.** Send a dummy right word, then left 0xA5A5A5 and right 0x5A5A5A at 24 bits/word with 17-clk half-periods → one pair {0xA5A5A5, 0x5A5A5A}; `locked` = 1; `short_word` = 0; `sample_valid` exactly 2 clk after the closing `bck` rise is seen.
- **Short word.** 16-bit words, left 0x1234 and right 0xABCD → {0x123400, 0xABCD00}; `short_word` = 1; `clear_flags` pulse → 0.
- **Overflow.** DEPTH = 4, `sample_ready` = 0, send 5 pairs → `sample_valid` = 1, `overflow` = 1. Popping returns pairs 1-4 in order; pair 5 is absent.
- **Simultaneous push/pop at full.** FIFO full, `sample_ready` = 1 in the push cycle → occupancy stays 4, `overflow` stays 0, and order is preserved.
- **Timeout mid-word.** Stop `bck` after 10 bits of a left word for 300 clk → `locked` = 0 at 255 clk. FIFO contents are still readable. When `bck` restarts, the first complete L/R pair is captured correctly.

Source files
------------

// File: rtl/i2s_frame_capture.sv
// I2S receiver that oversamples bck/ws/d0, deserializes MSB-first left/right words
// and buffers completed pairs in a show-ahead FIFO behind a valid/ready handshake.
module i2s_frame_capture #(
   parameter int WIDTH   = 24,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             i2s_bck,
   input  logic             i2s_ws,
   input  logic             i2s_d0,
   output logic [WIDTH-1:0] sample_left,
   output logic [WIDTH-1:0] sample_right,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             locked,
   output logic             short_word,
   output logic             overflow,
   input  logic             clear_flags
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = 2 * WIDTH;
   localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam logic [7:0]    TMO_C   = 8'(TIMEOUT);
   localparam logic [7:0]    TMO_M1  = 8'(TIMEOUT - 1);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

   typedef enum logic {ST_SYNC = 1'b0, ST_CAPTURE = 1'b1} state_t;

   logic             bck_q, bck_qq, ws_q, d0_q;
   state_t           state_q, state_d;
   logic             ws_prev_q, ws_prev_d;
   logic             chan_q, chan_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic             left_valid_q, left_valid_d;
   logic [7:0]       wd_q, wd_d;
   logic             push_q, push_d;
   logic [PW-1:0]    push_data_q, push_data_d;
   logic             locked_q, locked_d;
   logic             short_q, short_d;
   logic             ovf_q, ovf_d;
   logic [PW-1:0]    mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;

   logic             rise_s, timeout_s, short_set_s;
   logic [WIDTH-1:0] word_shift_s, word_final_s;
   logic [CW-1:0]    word_cnt_s;
   logic             full_s, pop_s, wr_en_s, ovf_set_s;

   assign rise_s    = bck_q & ~bck_qq;
   assign timeout_s = ~rise_s & (wd_q >= TMO_M1);

   // Word contents as they would be after this rise: one more bit unless already full width
   always_comb begin
      word_shift_s = shift_q;
      word_cnt_s   = bitcnt_q;
      if (bitcnt_q < WIDTH_C) begin
         word_shift_s = {shift_q[WIDTH-2:0], d0_q};
         word_cnt_s   = bitcnt_q + CNT_ONE;
      end else begin
         word_shift_s = shift_q;
         word_cnt_s   = bitcnt_q;
      end
      word_final_s = word_shift_s << (WIDTH_C - word_cnt_s);
   end

   // Alignment FSM, deserializer and watchdog next-state
   always_comb begin
      state_d      = state_q;
      ws_prev_d    = ws_prev_q;
      chan_d       = chan_q;
      bitcnt_d     = bitcnt_q;
      shift_d      = shift_q;
      left_hold_d  = left_hold_q;
      left_valid_d = left_valid_q;
      push_d       = 1'b0;
      push_data_d  = push_data_q;
      locked_d     = locked_q;
      short_set_s  = 1'b0;
      wd_d         = wd_q;

      if (rise_s) begin
         wd_d = 8'd0;
      end else if (wd_q != TMO_C) begin
         wd_d = wd_q + 8'd1;
      end else begin
         wd_d = wd_q;
      end

      if (timeout_s) begin
         // bit clock lost: drop the partial word and any unpaired left sample
         state_d      = ST_SYNC;
         bitcnt_d     = {CW{1'b0}};
         shift_d      = {WIDTH{1'b0}};
         left_valid_d = 1'b0;
         locked_d     = 1'b0;
      end else if (rise_s) begin
         ws_prev_d = ws_q;
         case (state_q)
            ST_SYNC: begin
               if (ws_q != ws_prev_q) begin
                  state_d  = ST_CAPTURE;
                  chan_d   = ws_q;
                  bitcnt_d = {CW{1'b0}};
                  shift_d  = {WIDTH{1'b0}};
               end else begin
                  state_d = ST_SYNC;
               end
            end
            ST_CAPTURE: begin
               if (ws_q == ws_prev_q) begin
                  shift_d  = word_shift_s;
                  bitcnt_d = word_cnt_s;
               end else begin
                  if (word_cnt_s != WIDTH_C) begin
                     short_set_s = 1'b1;
                  end else begin
                     short_set_s = 1'b0;
                  end
                  if (chan_q == 1'b0) begin
                     left_hold_d  = word_final_s;
                     left_valid_d = 1'b1;
                  end else if (left_valid_q) begin
                     push_d       = 1'b1;
                     push_data_d  = {left_hold_q, word_final_s};
                     left_valid_d = 1'b0;
                     locked_d     = 1'b1;
                  end else begin
                     left_valid_d = 1'b0;
                  end
                  chan_d   = ~chan_q;
                  bitcnt_d = {CW{1'b0}};
                  shift_d  = {WIDTH{1'b0}};
               end
            end
            default: begin
               state_d = ST_SYNC;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   assign full_s       = (occ_q == DEPTH_C);
   assign sample_valid = (occ_q != {(AW + 1){1'b0}});
   assign pop_s        = sample_valid & sample_ready;
   assign wr_en_s      = push_q & (~full_s | pop_s);
   assign ovf_set_s    = push_q & full_s & ~pop_s;

   // FIFO pointers, occupancy and sticky flags next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (wr_en_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
      if (short_set_s) begin
         short_d = 1'b1;
      end else if (clear_flags) begin
         short_d = 1'b0;
      end else begin
         short_d = short_q;
      end
      if (ovf_set_s) begin
         ovf_d = 1'b1;
      end else if (clear_flags) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetb) begin
         bck_q        <= 1'b0;
         bck_qq       <= 1'b0;
         ws_q         <= 1'b0;
         d0_q         <= 1'b0;
         state_q      <= ST_SYNC;
         ws_prev_q    <= 1'b0;
         chan_q       <= 1'b0;
         bitcnt_q     <= {CW{1'b0}};
         shift_q      <= {WIDTH{1'b0}};
         left_hold_q  <= {WIDTH{1'b0}};
         left_valid_q <= 1'b0;
         wd_q         <= 8'd0;
         push_q       <= 1'b0;
         push_data_q  <= {PW{1'b0}};
         locked_q     <= 1'b0;
         short_q      <= 1'b0;
         ovf_q        <= 1'b0;
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         occ_q        <= {(AW + 1){1'b0}};
      end else begin
         bck_q        <= i2s_bck;
         bck_qq       <= bck_q;
         ws_q         <= i2s_ws;
         d0_q         <= i2s_d0;
         state_q      <= state_d;
         ws_prev_q    <= ws_prev_d;
         chan_q       <= chan_d;
         bitcnt_q     <= bitcnt_d;
         shift_q      <= shift_d;
         left_hold_q  <= left_hold_d;
         left_valid_q <= left_valid_d;
         wd_q         <= wd_d;
         push_q       <= push_d;
         push_data_q  <= push_data_d;
         locked_q     <= locked_d;
         short_q      <= short_d;
         ovf_q        <= ovf_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
      end
   end

   // FIFO storage; entries beyond occupancy are never observed, so no reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= push_data_q;
      end
   end

   assign sample_left  = sample_valid ? mem_q[rd_ptr_q][PW-1:WIDTH] : {WIDTH{1'b0}};
   assign sample_right = sample_valid ? mem_q[rd_ptr_q][WIDTH-1:0]  : {WIDTH{1'b0}};
   assign locked       = locked_q;
   assign short_word   = short_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_i2s_frame_capture.sv
// Directed bench for i2s_frame_capture: drives an I2S stream with 17-clk bck half-periods
// and checks popped pairs against a queue of expected pairs.
module tb_i2s_frame_capture;

   localparam int W = 24;
   localparam int H = 17;

   logic          clk = 1'b0;
   logic          resetb, i2s_bck, i2s_ws, i2s_d0, sample_ready, clear_flags;
   logic [W-1:0]  sample_left, sample_right;
   logic          sample_valid, locked, short_word, overflow;

   int            checks = 0;
   int            errors = 0;
   logic [47:0]   exp_q[$];
   logic          pend = 1'b0;

   always #5 clk = ~clk;

   i2s_frame_capture #(.WIDTH(W), .DEPTH(4), .TIMEOUT(255)) dut (
      .clk(clk), .resetb(resetb), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws), .i2s_d0(i2s_d0),
      .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .locked(locked), .short_word(short_word),
      .overflow(overflow), .clear_flags(clear_flags)
   );

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic slot(input logic ws, input logic d);
      i2s_ws = ws; i2s_d0 = d; i2s_bck = 1'b0;
      tick(H);
      i2s_bck = 1'b1;
      tick(H);
   endtask

   // one word frame: first slot carries the previous word's LSB (one-bit I2S delay)
   task automatic send_word(input logic c, input logic [23:0] val, input int n);
      slot(c, pend);
      for (int i = n - 1; i >= 1; i--) slot(c, val[i]);
      pend = val[0];
   endtask

   // first slot of a new left word: closes the pending right word
   task automatic flush(input bit chk_lat, input bit pop_at_push);
      logic [47:0] e;
      i2s_ws = 1'b0; i2s_d0 = pend; i2s_bck = 1'b0;
      tick(H);
      i2s_bck = 1'b1;
      tick(1);
      if (chk_lat) chk("lat_k0", sample_valid, 48'd0);
      tick(1);
      if (chk_lat) chk("lat_k1", sample_valid, 48'd0);
      if (pop_at_push) begin
         e = exp_q.pop_front();
         chk("simul_head", {sample_left, sample_right}, e);
         sample_ready = 1'b1;
      end
      tick(1);
      sample_ready = 1'b0;
      if (chk_lat) chk("lat_k2", sample_valid, 48'd1);
      tick(H - 3);
   endtask

   task automatic pop_check(input string tag);
      int t;
      logic [47:0] e;
      t = 0;
      while (!sample_valid && t < 200) begin
         tick(1);
         t++;
      end
      chk({tag, "_valid"}, sample_valid, 48'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 48'd0;
      chk(tag, {sample_left, sample_right}, e);
      sample_ready = 1'b1;
      tick(1);
      sample_ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [23:0] l, r;
      // reset with random inputs
      resetb = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i2s_bck = 1'($urandom); i2s_ws = 1'($urandom); i2s_d0 = 1'($urandom);
         sample_ready = 1'($urandom); clear_flags = 1'($urandom);
         tick(1);
      end
      chk("rst_left", sample_left, 48'd0);
      chk("rst_right", sample_right, 48'd0);
      chk("rst_valid", sample_valid, 48'd0);
      chk("rst_locked", locked, 48'd0);
      chk("rst_short", short_word, 48'd0);
      chk("rst_ovf", overflow, 48'd0);
      i2s_bck = 1'b0; i2s_ws = 1'b0; i2s_d0 = 1'b0; sample_ready = 1'b0; clear_flags = 1'b0;
      tick(1);
      resetb = 1'b1;
      tick(2);

      // basic capture
      send_word(1'b1, 24'h000000, 24);
      send_word(1'b0, 24'hA5A5A5, 24);
      send_word(1'b1, 24'h5A5A5A, 24);
      exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
      flush(1'b1, 1'b0);
      chk("basic_locked", locked, 48'd1);
      chk("basic_short", short_word, 48'd0);
      pop_check("basic_pair");
      chk("basic_empty", sample_valid, 48'd0);
      tick(300);

      // short words
      send_word(1'b1, 24'h000000, 24);
      send_word(1'b0, 24'h001234, 16);
      send_word(1'b1, 24'h00ABCD, 16);
      exp_q.push_back({24'h123400, 24'hABCD00});
      flush(1'b0, 1'b0);
      chk("short_set", short_word, 48'd1);
      pop_check("short_pair");
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
      chk("short_clr", short_word, 48'd0);
      tick(300);

      // overflow: five pairs into four entries
      send_word(1'b1, 24'h000000, 24);
      for (int p = 1; p <= 5; p++) begin
         l = 24'(24'h111111 * p);
         r = ~l;
         send_word(1'b0, l, 24);
         send_word(1'b1, r, 24);
         if (p <= 4) exp_q.push_back({l, r});
      end
      flush(1'b0, 1'b0);
      chk("ovf_valid", sample_valid, 48'd1);
      chk("ovf_flag", overflow, 48'd1);
      for (int p = 0; p < 4; p++) pop_check("ovf_pair");
      chk("ovf_drained", sample_valid, 48'd0);
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
      chk("ovf_clr", overflow, 48'd0);
      tick(300);

      // push and pop in the same cycle while full
      send_word(1'b1, 24'h000000, 24);
      for (int p = 6; p <= 10; p++) begin
         l = 24'(24'h0F0F01 * p);
         r = l ^ 24'hFFF000;
         send_word(1'b0, l, 24);
         send_word(1'b1, r, 24);
         exp_q.push_back({l, r});
      end
      flush(1'b0, 1'b1);
      chk("simul_ovf", overflow, 48'd0);
      for (int p = 0; p < 4; p++) pop_check("simul_pair");
      chk("simul_drained", sample_valid, 48'd0);
      tick(300);

      // loss of bit clock in the middle of a left word
      send_word(1'b1, 24'h000000, 24);
      send_word(1'b0, 24'hC3C3C3, 24);
      send_word(1'b1, 24'h3C3C3C, 24);
      exp_q.push_back({24'hC3C3C3, 24'h3C3C3C});
      slot(1'b0, pend);
      for (int i = 0; i < 10; i++) slot(1'b0, 1'($urandom));
      tick(100);
      chk("tmo_still_locked", locked, 48'd1);
      tick(200);
      chk("tmo_unlocked", locked, 48'd0);
      pop_check("tmo_kept");
      pend = 1'b0;
      send_word(1'b1, 24'h000000, 24);
      send_word(1'b0, 24'h13579B, 24);
      send_word(1'b1, 24'h2468AC, 24);
      exp_q.push_back({24'h13579B, 24'h2468AC});
      flush(1'b0, 1'b0);
      pop_check("tmo_resync");
      chk("tmo_relocked", locked, 48'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
